// File: rtl/lbuf_pingpong_ctrl.sv
`timescale 1ns/1ps
// lbuf_pingpong_ctrl
// Ping-pong sequencer for a 2^AW x DW dual-port sprite line buffer.
// The draw bank (BANK) takes sprite writes on port 0. The display bank (~BANK) is
// read on port 1, and each pixel is cleared on that port right after it is read.
// After reset, an init sweep writes CLR_VAL to every RAM word.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   line_swp_i                line pulse, toggles the draw/display banks
//   sp_we_i/sp_x_i/sp_di_i    sprite pixel write request
//   pix_en_i/pix_x_i          display read request
//   pix_do_o/pix_vld_o        display pixel data and one-cycle valid
//   pix_err_o                 sticky flag for back-to-back read requests
//   ready_o, bank_o           init-done flag, current draw bank
//   lb_*0_o                   RAM port 0 (write only)
//   lb_*1_o, lb_do1_i         RAM port 1 (read/clear, registered read data)
module lbuf_pingpong_ctrl #(
   parameter int unsigned    AW      = 10,
   parameter int unsigned    DW      = 8,
   parameter logic [DW-1:0]  CLR_VAL = 8'h0F,
   parameter logic [DW-1:0]  TMASK   = 8'h0F
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            line_swp_i,
   input  logic            sp_we_i,
   input  logic [AW-2:0]   sp_x_i,
   input  logic [DW-1:0]   sp_di_i,
   input  logic            pix_en_i,
   input  logic [AW-2:0]   pix_x_i,
   output logic [DW-1:0]   pix_do_o,
   output logic            pix_vld_o,
   output logic            pix_err_o,
   output logic            ready_o,
   output logic            bank_o,
   output logic [AW-1:0]   lb_ad0_o,
   output logic            lb_wr0_o,
   output logic [DW-1:0]   lb_di0_o,
   output logic [AW-1:0]   lb_ad1_o,
   output logic            lb_wr1_o,
   output logic [DW-1:0]   lb_di1_o,
   input  logic [DW-1:0]   lb_do1_i
);

   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] CNT_END = {1'b1, {AW{1'b0}}};

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            bank_q, bank_d;
   logic            ready_q, ready_d;
   logic            rd_pend_q, rd_pend_d;
   logic [DW-1:0]   pix_do_q, pix_do_d;
   logic            pix_vld_q, pix_vld_d;
   logic            pix_err_q, pix_err_d;
   logic [AW-1:0]   lb_ad0_q, lb_ad0_d;
   logic            lb_wr0_q, lb_wr0_d;
   logic [DW-1:0]   lb_di0_q, lb_di0_d;
   logic [AW-1:0]   lb_ad1_q, lb_ad1_d;
   logic            lb_wr1_q, lb_wr1_d;
   logic [DW-1:0]   lb_di1_q, lb_di1_d;
   logic            rd_now_c;
   logic            transp_c;

   assign transp_c = ((sp_di_i & TMASK) == (CLR_VAL & TMASK));

   // State register and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_INIT;
         cnt_q     <= '0;
         bank_q    <= 1'b0;
         ready_q   <= 1'b0;
         rd_pend_q <= 1'b0;
         pix_do_q  <= '0;
         pix_vld_q <= 1'b0;
         pix_err_q <= 1'b0;
         lb_ad0_q  <= '0;
         lb_wr0_q  <= 1'b0;
         lb_di0_q  <= '0;
         lb_ad1_q  <= '0;
         lb_wr1_q  <= 1'b0;
         lb_di1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bank_q    <= bank_d;
         ready_q   <= ready_d;
         rd_pend_q <= rd_pend_d;
         pix_do_q  <= pix_do_d;
         pix_vld_q <= pix_vld_d;
         pix_err_q <= pix_err_d;
         lb_ad0_q  <= lb_ad0_d;
         lb_wr0_q  <= lb_wr0_d;
         lb_di0_q  <= lb_di0_d;
         lb_ad1_q  <= lb_ad1_d;
         lb_wr1_q  <= lb_wr1_d;
         lb_di1_q  <= lb_di1_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      ready_d   = ready_q;
      rd_pend_d = 1'b0;
      pix_do_d  = pix_do_q;
      pix_vld_d = 1'b0;
      pix_err_d = pix_err_q;
      lb_ad0_d  = lb_ad0_q;
      lb_wr0_d  = 1'b0;
      lb_di0_d  = lb_di0_q;
      lb_ad1_d  = lb_ad1_q;
      lb_wr1_d  = 1'b0;
      lb_di1_d  = lb_di1_q;
      rd_now_c  = 1'b0;

      case (state_q)
         S_INIT: begin
            if (cnt_q == CNT_END) begin
               ready_d = 1'b1;
               state_d = S_RUN;
            end else begin
               lb_ad1_d = cnt_q[AW-1:0];
               lb_wr1_d = 1'b1;
               lb_di1_d = CLR_VAL;
               cnt_d    = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (line_swp_i) begin
               bank_d = ~bank_q;
            end
            if (sp_we_i && !transp_c) begin
               lb_ad0_d = {bank_q, sp_x_i};
               lb_wr0_d = 1'b1;
               lb_di0_d = sp_di_i;
            end
            // A read is never accepted during its predecessor's clear cycle,
            // so the clear slot on port 1 is always free.
            if (pix_en_i) begin
               if (rd_pend_q) begin
                  pix_err_d = 1'b1;
               end else begin
                  rd_now_c  = 1'b1;
                  rd_pend_d = 1'b1;
                  lb_ad1_d  = {~bank_q, pix_x_i};
                  lb_wr1_d  = 1'b1;
                  lb_di1_d  = CLR_VAL;
               end
            end
            if (rd_pend_q) begin
               pix_do_d  = lb_do1_i;
               pix_vld_d = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // The read address is presented in the request cycle itself so the
   // registered RAM returns data in time for the clear cycle.
   assign lb_ad1_o  = rd_now_c ? lb_ad1_d : lb_ad1_q;
   assign lb_wr1_o  = lb_wr1_q;
   assign lb_di1_o  = lb_di1_q;
   assign lb_ad0_o  = lb_ad0_q;
   assign lb_wr0_o  = lb_wr0_q;
   assign lb_di0_o  = lb_di0_q;
   assign pix_do_o  = pix_do_q;
   assign pix_vld_o = pix_vld_q;
   assign pix_err_o = pix_err_q;
   assign ready_o   = ready_q;
   assign bank_o    = bank_q;

endmodule

// File: tb/tb_lbuf_pingpong_ctrl.sv
`timescale 1ns/1ps
// Bench for lbuf_pingpong_ctrl: line RAM model, per-bank reference pixel
// array, and queues of expected port-0 writes and display pixels.
module tb_lbuf_pingpong_ctrl;

   logic        clk, rst_n;
   logic        line_swp, sp_we, pix_en;
   logic [8:0]  sp_x, pix_x;
   logic [7:0]  sp_di;
   logic [7:0]  pix_do;
   logic        pix_vld, pix_err, ready, bank;
   logic [9:0]  lb_ad0, lb_ad1;
   logic        lb_wr0, lb_wr1;
   logic [7:0]  lb_di0, lb_di1, lb_do1;

   lbuf_pingpong_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .line_swp_i(line_swp),
      .sp_we_i(sp_we), .sp_x_i(sp_x), .sp_di_i(sp_di),
      .pix_en_i(pix_en), .pix_x_i(pix_x),
      .pix_do_o(pix_do), .pix_vld_o(pix_vld), .pix_err_o(pix_err),
      .ready_o(ready), .bank_o(bank),
      .lb_ad0_o(lb_ad0), .lb_wr0_o(lb_wr0), .lb_di0_o(lb_di0),
      .lb_ad1_o(lb_ad1), .lb_wr1_o(lb_wr1), .lb_di1_o(lb_di1),
      .lb_do1_i(lb_do1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port line RAM, registered read on port 1
   logic [7:0] mem [1024];
   always @(posedge clk) begin
      if (lb_wr0) mem[lb_ad0] <= lb_di0;
      if (lb_wr1) mem[lb_ad1] <= lb_di1;
      lb_do1 <= mem[lb_ad1];
   end

   int n_chk  = 0;
   int n_fail = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference model state
   logic [7:0]  ref_mem [2][512];
   logic        m_bank;
   logic        m_prev_acc;
   logic        m_err;
   logic [17:0] wq[$];
   logic [7:0]  pq[$];

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int x = 0; x < 512; x++) ref_mem[b][x] = 8'h0F;
      m_bank = 1'b0; m_prev_acc = 1'b0; m_err = 1'b0;
   endtask

   // Monitor: pop and compare whenever the DUT presents a write or a pixel
   always @(negedge clk) begin
      if (rst_n) begin
         if (lb_wr0) begin
            if (wq.size() == 0) check("port0_unexpected_write", {lb_ad0, lb_di0}, 64'h0);
            else check("port0_write", {lb_ad0, lb_di0}, wq.pop_front());
         end
         if (pix_vld) begin
            if (pq.size() == 0) check("pixel_unexpected", {55'h0, 1'b1, pix_do}, 64'h0);
            else check("pixel_data", pix_do, pq.pop_front());
         end
      end
   end

   // One RUN cycle: drive inputs after the edge, update model, stop at negedge
   task automatic step(input logic swp, input logic we, input logic [8:0] sx, input logic [7:0] sdi,
                       input logic pe, input logic [8:0] px);
      @(posedge clk); #1;
      line_swp = swp; sp_we = we; sp_x = sx; sp_di = sdi; pix_en = pe; pix_x = px;
      if (we && ((sdi & 8'h0F) != 8'h0F)) begin
         ref_mem[m_bank][sx] = sdi;
         wq.push_back({m_bank, sx, sdi});
      end
      if (pe && m_prev_acc) begin
         m_err = 1'b1;
         m_prev_acc = 1'b0;
      end else if (pe) begin
         pq.push_back(ref_mem[~m_bank][px]);
         ref_mem[~m_bank][px] = 8'h0F;
         m_prev_acc = 1'b1;
      end else begin
         m_prev_acc = 1'b0;
      end
      if (swp) m_bank = ~m_bank;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 9'h0, 8'h0, 1'b0, 9'h0);
   endtask

   // Follows reset release (made at a negedge): 1024 clear writes, then READY
   task automatic check_sweep();
      for (int k = 0; k < 1024; k++) begin
         @(posedge clk); @(negedge clk);
         check("init_sweep", {ready, lb_wr1, lb_ad1, lb_di1, lb_wr0}, {1'b0, 1'b1, 10'(k), 8'h0F, 1'b0});
      end
      @(posedge clk); @(negedge clk);
      check("init_done", {ready, lb_wr1, bank}, {1'b1, 1'b0, 1'b0});
   endtask

   task automatic check_all_zero(input string name);
      check(name, {pix_do, pix_vld, pix_err, ready, bank, lb_ad0, lb_wr0, lb_di0, lb_ad1, lb_wr1, lb_di1}, 64'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] sx, px;
      logic       we, pe;
      rst_n = 1'b0;
      line_swp = 0; sp_we = 0; sp_x = 0; sp_di = 0; pix_en = 0; pix_x = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset_outputs");
      @(negedge clk); rst_n = 1'b1;
      check_sweep();

      // Sprite path: opaque then transparent pixel
      step(1'b0, 1'b1, 9'h012, 8'h35, 1'b0, 9'h0);
      step(1'b0, 1'b1, 9'h012, 8'h2F, 1'b0, 9'h0);
      check("sp_write", {lb_wr0, lb_ad0, lb_di0}, {1'b1, 10'h012, 8'h35});
      step(1'b0, 1'b1, 9'h005, 8'h35, 1'b0, 9'h0);
      check("sp_transparent", lb_wr0, 1'b0);
      step(1'b1, 1'b0, 9'h0, 8'h0, 1'b0, 9'h0);
      idle();
      check("bank_after_swap", bank, 1'b1);

      // Display read/clear of X=5 from the bank just drawn (bank 0)
      step(1'b0, 1'b0, 9'h0, 8'h0, 1'b1, 9'h005);
      check("rd_addr", {lb_ad1, lb_wr1}, {10'h005, 1'b0});
      idle();
      check("clr_cycle", {lb_ad1, lb_wr1, lb_di1, pix_vld}, {10'h005, 1'b1, 8'h0F, 1'b0});
      idle();
      check("pix_vld_t2", {pix_vld, pix_do}, {1'b1, 8'h35});
      step(1'b0, 1'b0, 9'h0, 8'h0, 1'b1, 9'h005);
      idle(); idle();
      check("pix_err_clear", pix_err, 1'b0);

      // Back-to-back read requests
      step(1'b0, 1'b0, 9'h0, 8'h0, 1'b1, 9'h007);
      step(1'b0, 1'b0, 9'h0, 8'h0, 1'b1, 9'h008);
      check("b2b_clear_addr", {lb_ad1, lb_wr1}, {10'h007, 1'b1});
      idle();
      check("pix_err_set", pix_err, m_err);
      idle();
      check("pix_err_sticky", pix_err, 1'b1);

      // Swap together with a sprite write: write lands in the old bank
      step(1'b1, 1'b1, 9'h009, 8'h44, 1'b0, 9'h0);
      check("bank_same_cycle", bank, 1'b1);
      idle();
      check("swap_write", {bank, lb_wr0, lb_ad0}, {1'b0, 1'b1, 10'h209});

      // Randomised lines
      for (int ln = 0; ln < 20; ln++) begin
         for (int c = 0; c < 40; c++) begin
            we = 1'($urandom_range(0, 1));
            pe = (c != 0) && ($urandom_range(0, 2) == 0);
            sx = 9'($urandom_range(0, 15));
            px = 9'($urandom_range(0, 15));
            step(1'b0, we, sx, 8'($urandom_range(0, 255)), pe, px);
         end
         step(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)));
      end
      repeat (4) idle();
      check("wq_drained", 64'(wq.size()), 64'h0);
      check("pq_drained", 64'(pq.size()), 64'h0);
      check("pix_err_final", pix_err, m_err);

      // Reset in the middle of a fresh init sweep
      rst_n = 1'b0; #1;
      @(negedge clk); rst_n = 1'b1;
      repeat (300) @(posedge clk);
      @(negedge clk);
      check("sweep_at_300", {lb_wr1, lb_ad1}, {1'b1, 10'd299});
      rst_n = 1'b0; #1;
      check_all_zero("midsweep_reset");
      wq.delete(); pq.delete();
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      check_sweep();
      step(1'b0, 1'b1, 9'h003, 8'h5A, 1'b1, 9'h003);
      repeat (3) idle();
      check("post_reset_err", pix_err, 1'b0);
      check("post_reset_pq", 64'(pq.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
